// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter that shares one registered bitwise gate unit among
// NUM_REQ requesters, returning each result with its owner's ID.
module gate_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [3*NUM_REQ-1:0]     op,
  input  logic [WIDTH*NUM_REQ-1:0] a,
  input  logic [WIDTH*NUM_REQ-1:0] b,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic [15:0]              done_count,
  output logic                     busy
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_XNOR = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_BAD6 = 3'd6,
    OP_BAD7 = 3'd7
  } op_e;

  logic [ID_W-1:0]  lp;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic             can_issue;
  int               scan_idx;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] gate_data;
  logic             gate_err;

  // Scan starts just after the last granted index so every requester gets a turn.
  always_comb begin
    can_issue = !rsp_valid || rsp_ready;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    scan_idx  = 0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    if (!rst && can_issue) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        scan_idx = (int'(lp) + k) % NUM_REQ;
        if (!gnt_any && req[scan_idx]) begin
          gnt[scan_idx] = 1'b1;
          gnt_idx       = ID_W'(scan_idx);
          gnt_any       = 1'b1;
          sel_op        = op[3*scan_idx +: 3];
          sel_a         = a[WIDTH*scan_idx +: WIDTH];
          sel_b         = b[WIDTH*scan_idx +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    gate_data = '0;
    gate_err  = 1'b0;
    case (op_e'(sel_op))
      OP_AND:  gate_data = sel_a & sel_b;
      OP_OR:   gate_data = sel_a | sel_b;
      OP_XOR:  gate_data = sel_a ^ sel_b;
      OP_XNOR: gate_data = ~(sel_a ^ sel_b);
      OP_NAND: gate_data = ~(sel_a & sel_b);
      OP_NOR:  gate_data = ~(sel_a | sel_b);
      default: gate_err  = 1'b1;
    endcase
  end

  // A new acceptance overwrites the response in the same edge the old one retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      done_count <= '0;
      lp         <= ID_W'(NUM_REQ - 1);
    end else begin
      if (rsp_valid && rsp_ready)
        done_count <= done_count + 16'd1;
      if (gnt_any) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gnt_idx;
        rsp_data  <= gate_data;
        rsp_err   <= gate_err;
        lp        <= gnt_idx;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = rsp_valid || (|req);

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Self-checking bench for gate_unit_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_gate_unit_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [3*NUM_REQ-1:0]     op;
  logic [WIDTH*NUM_REQ-1:0] a;
  logic [WIDTH*NUM_REQ-1:0] b;
  logic [NUM_REQ-1:0]       gnt;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_err;
  logic [15:0]              done_count;
  logic                     busy;

  gate_unit_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .done_count(done_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         opArr [NUM_REQ];
  logic [7:0] aArr  [NUM_REQ];
  logic [7:0] bArr  [NUM_REQ];

  bit         curRst;
  logic [3:0] curReq;
  bit         curReady;

  // Reference model: the state a consumer would observe on the response side.
  bit         mValid;
  int         mId;
  logic [7:0] mData;
  bit         mErr;
  int         mCount;
  int         mLp;

  logic [7:0] sweep [6];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int modelGrant();
    if (curRst) return -1;
    if (mValid && !curReady) return -1;
    for (int off = 1; off <= NUM_REQ; off++) begin
      int idx;
      idx = (mLp + off) % NUM_REQ;
      if (curReq[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [8:0] modelGate(input int o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      0: return {1'b0, x & y};
      1: return {1'b0, x | y};
      2: return {1'b0, x ^ y};
      3: return {1'b0, ~(x ^ y)};
      4: return {1'b0, ~(x & y)};
      5: return {1'b0, ~(x | y)};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  task automatic applyStimulus(input bit r, input logic [3:0] rq, input bit rdy);
    curRst   = r;
    curReq   = rq;
    curReady = rdy;
    for (int i = 0; i < NUM_REQ; i++) begin
      op[3*i +: 3]         = 3'(opArr[i]);
      a[WIDTH*i +: WIDTH]  = aArr[i];
      b[WIDTH*i +: WIDTH]  = bArr[i];
    end
    rst       = r;
    req       = rq;
    rsp_ready = rdy;
    #1;
  endtask

  task automatic compareModel();
    int g;
    g = modelGrant();
    checkOutput("gnt", 32'(gnt), (g < 0) ? 32'd0 : (32'd1 << g));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(mValid));
    if (mValid) begin
      checkOutput("rsp_id", 32'(rsp_id), 32'(mId));
      checkOutput("rsp_data", 32'(rsp_data), 32'(mData));
      checkOutput("rsp_err", 32'(rsp_err), 32'(mErr));
    end
    checkOutput("done_count", 32'(done_count), 32'(mCount));
    checkOutput("busy", 32'(busy), 32'(mValid || (curReq != 0)));
  endtask

  task automatic advance();
    int g;
    logic [8:0] r;
    g = modelGrant();
    @(posedge clk);
    if (curRst) begin
      mValid = 0; mId = 0; mData = 0; mErr = 0; mCount = 0; mLp = NUM_REQ - 1;
    end else begin
      if (mValid && curReady) mCount = (mCount + 1) % 65536;
      if (g >= 0) begin
        r      = modelGate(opArr[g], aArr[g], bArr[g]);
        mValid = 1;
        mId    = g;
        mData  = r[7:0];
        mErr   = r[8];
        mLp    = g;
      end else if (curReady) begin
        mValid = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input bit r, input logic [3:0] rq, input bit rdy);
    applyStimulus(r, rq, rdy);
    compareModel();
    advance();
  endtask

  initial begin
    sweep[0] = 8'h05; sweep[1] = 8'hAF; sweep[2] = 8'hAA;
    sweep[3] = 8'h55; sweep[4] = 8'hFA; sweep[5] = 8'h50;
    for (int i = 0; i < NUM_REQ; i++) begin
      opArr[i] = 0; aArr[i] = '0; bArr[i] = '0;
    end
    rst = 1'b1; req = '0; op = '0; a = '0; b = '0; rsp_ready = 1'b1;
    @(negedge clk);
    applyStimulus(1, 4'b0000, 1);
    advance();

    $display("[TB] basic AND on requester 0");
    opArr[0] = 0; aArr[0] = 8'hF0; bArr[0] = 8'hCC;
    applyStimulus(0, 4'b0001, 1);
    compareModel();
    checkOutput("t1_gnt", 32'(gnt), 32'h1);
    advance();
    applyStimulus(0, 4'b0000, 1);
    compareModel();
    checkOutput("t1_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t1_data", 32'(rsp_data), 32'hC0);
    checkOutput("t1_id", 32'(rsp_id), 32'h0);
    advance();

    $display("[TB] op sweep on requester 2");
    step(1, 4'b0000, 1);
    for (int k = 0; k < 6; k++) begin
      opArr[2] = k; aArr[2] = 8'hA5; bArr[2] = 8'h0F;
      applyStimulus(0, 4'b0100, 1);
      compareModel();
      if (k > 0) checkOutput("t2_data", 32'(rsp_data), 32'(sweep[k-1]));
      advance();
    end
    applyStimulus(0, 4'b0000, 1);
    compareModel();
    checkOutput("t2_data_last", 32'(rsp_data), 32'(sweep[5]));
    advance();
    applyStimulus(0, 4'b0000, 1);
    compareModel();
    checkOutput("t2_count", 32'(done_count), 32'd6);
    advance();

    $display("[TB] round-robin with all requesting");
    step(1, 4'b0000, 1);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        opArr[i] = $urandom_range(0, 5);
        aArr[i]  = 8'($urandom);
        bArr[i]  = 8'($urandom);
      end
      applyStimulus(0, 4'b1111, 1);
      compareModel();
      checkOutput("t3_gnt", 32'(gnt), 32'd1 << (k % 4));
      if (k > 0) checkOutput("t3_id", 32'(rsp_id), 32'((k - 1) % 4));
      advance();
    end

    $display("[TB] back-pressure hold");
    step(1, 4'b0000, 1);
    opArr[1] = 1; aArr[1] = 8'h3C; bArr[1] = 8'h81;
    step(0, 4'b0010, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 4'b0010, 0);
      compareModel();
      checkOutput("t4_hold_gnt", 32'(gnt), 32'h0);
      checkOutput("t4_hold_data", 32'(rsp_data), 32'hBD);
      advance();
    end
    applyStimulus(0, 4'b0010, 1);
    compareModel();
    checkOutput("t4_regrant", 32'(gnt), 32'h2);
    advance();

    $display("[TB] illegal op");
    opArr[1] = 7;
    step(0, 4'b0010, 1);
    applyStimulus(0, 4'b0000, 1);
    compareModel();
    checkOutput("t5_err", 32'(rsp_err), 32'h1);
    checkOutput("t5_data", 32'(rsp_data), 32'h0);
    advance();

    $display("[TB] reset mid-operation");
    opArr[3] = 2; aArr[3] = 8'h11; bArr[3] = 8'h22;
    step(0, 4'b1000, 0);
    applyStimulus(1, 4'b1000, 0);
    compareModel();
    checkOutput("t6_rst_gnt", 32'(gnt), 32'h0);
    advance();
    applyStimulus(0, 4'b1010, 1);
    compareModel();
    checkOutput("t6_valid", 32'(rsp_valid), 32'h0);
    checkOutput("t6_count", 32'(done_count), 32'h0);
    checkOutput("t6_first", 32'(gnt), 32'h2);
    advance();

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        opArr[i] = $urandom_range(0, 7);
        aArr[i]  = 8'($urandom);
        bArr[i]  = 8'($urandom);
      end
      step(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
